// File: rtl/mem_arbiter_if.sv
// Requester-side port of the memory arbiter: one instance per requester (CPU, debug/loader).
// Carries the request level, access attributes, completion pulse and read-back data.
interface mem_arbiter_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 5
);
    // Handshake: the master raises req with rnw/addr/wdata stable and holds them until
    // ack; ack is a single-cycle pulse, and req must be low again in the cycle after ack
    // (a req still high when the arbiter returns to idle is taken as a new request).
    logic              req;
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              ack;
    logic [WORD_W-1:0] rdata;

    modport master (
        output req, rnw, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, rnw, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM between the CPU sequencer and the debug/loader port: round-robin on
// contention, a fixed ACC_CYCLES chip-select window per access, then a one-cycle ack.
module mem_arbiter #(
    parameter int WORD_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int ACC_CYCLES = 2
) (
    input  logic              clock,
    input  logic              n_reset,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      dbg,
    output logic              mem_cs,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy,
    output logic [1:0]        state_dbg   // 0=IDLE, 1=ACCESS, 2=ACK
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              cpu_ack_q;
    logic              dbg_ack_q;
    logic [WORD_W-1:0] cpu_rdata_q;
    logic [WORD_W-1:0] dbg_rdata_q;
    logic              pick_dbg;

    // Debug wins when it asks alone, or when both ask and the CPU was served last.
    assign pick_dbg = dbg.req && (!cpu.req || !owner);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mem_cs      <= 1'b0;
            mem_rnw     <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            busy        <= 1'b0;
            owner       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu.req || dbg.req) begin
                        owner     <= pick_dbg;
                        mem_rnw   <= pick_dbg ? dbg.rnw   : cpu.rnw;
                        mem_addr  <= pick_dbg ? dbg.addr  : cpu.addr;
                        mem_wdata <= pick_dbg ? dbg.wdata : cpu.wdata;
                        mem_cs    <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= CNT_INIT;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        // RAM data is valid on the last access cycle; only reads touch rdata.
                        if (mem_rnw) begin
                            if (owner) dbg_rdata_q <= mem_rdata;
                            else       cpu_rdata_q <= mem_rdata;
                        end
                        mem_cs  <= 1'b0;
                        mem_rnw <= 1'b1;
                        if (owner) dbg_ack_q <= 1'b1;
                        else       cpu_ack_q <= 1'b1;
                        state   <= S_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    cpu_ack_q <= 1'b0;
                    dbg_ack_q <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu.ack   = cpu_ack_q;
    assign cpu.rdata = cpu_rdata_q;
    assign dbg.ack   = dbg_ack_q;
    assign dbg.rdata = dbg_rdata_q;
    assign state_dbg = state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single RAM between the CPU sequencer and a debug/loader port, which preloads and inspects programme memory from the board switches. Sits between the requesters and the RAM. It serialises accesses and applies round-robin priority on contention. It drives the RAM chip-select and read/write strobes for a fixed multi-cycle access window, then returns read data and a one-cycle acknowledge to the winning requester.

## Interface
- WORD_W, 8, data word width
- ADDR_W, 5, memory address width (WORD_W-OP_W in the CPU)
- ACC_CYCLES, 2, cycles mem_cs is held per access; legal range 1..15
- clock  input  1  system clock, rising-edge active
- n_reset  input  1  reset; one clock, reset asynchronous and active-low
- cpu_req  input  1  CPU access request, level
- cpu_rnw  input  1  CPU 1=read, 0=write
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  WORD_W  CPU write data
- cpu_ack  output  1  one-cycle completion pulse to CPU
- cpu_rdata  output  WORD_W  last data read by CPU, registered
- dbg_req, dbg_rnw, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as cpu_* for the debug/loader port
- mem_cs  output  1  RAM chip select
- mem_rnw  output  1  RAM 1=read, 0=write
- mem_addr  output  ADDR_W  RAM address, registered
- mem_wdata  output  WORD_W  RAM write data, registered
- mem_rdata  input  WORD_W  RAM read data, valid on last access cycle
- owner  output  1  current or last grant: 0=CPU, 1=debug
- busy  output  1  high in ACCESS and ACK

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: requests are sampled only here.
  - One request: grant it.
  - Both requests: grant the port not served last (round-robin via owner).
  - On grant: latch rnw/addr/wdata of the winner into mem_*, set owner, load counter with ACC_CYCLES-1, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_cs=1; mem_rnw, mem_addr and mem_wdata are held stable.
  - Counter decrements each cycle.
  - At counter 0, if read: capture mem_rdata into the owner's rdata register; the other port's rdata is unchanged. Then go to ACK.
- ACK: mem_cs=0; the owner's ack=1 for exactly this cycle; go to IDLE.
- A requester must deassert req in the cycle after its ack. A req still high on return to IDLE is a new request.
- A req dropped during ACCESS does not abort the access; the ack is still issued.
- When not in ACCESS: mem_cs=0 and mem_rnw=1. mem_addr and mem_wdata keep their last values.
- rdata registers are never altered by writes.

## Timing
- Reset (asynchronous, immediate) drives:
  - state IDLE, counter 0;
  - mem_cs=0, mem_rnw=1, mem_addr=0, mem_wdata=0;
  - cpu_ack=dbg_ack=0, cpu_rdata=dbg_rdata=0, busy=0;
  - owner=1, so the CPU wins the first contention.
- Reset during ACCESS aborts the transaction: mem_cs falls at once and no ack is issued.
- req high at clock edge E0 while IDLE:
  - mem_cs high for cycles E0..E0+ACC_CYCLES-1;
  - ack high for the cycle starting at edge E0+ACC_CYCLES;
  - IDLE at edge E0+ACC_CYCLES+1.
- Minimum period per transaction: ACC_CYCLES+2 cycles (4 at default).
- Read data appears on xxx_rdata in the same cycle as xxx_ack and holds afterwards.
- With both ports requesting continuously, grants strictly alternate.
- ACC_CYCLES=1: ACCESS lasts one cycle; the period is 3 cycles.

## Test plan
- Reset with both req high, release n_reset -> CPU granted first: owner=0, mem_cs high 2 cycles, cpu_ack pulse; then debug is served (owner=1).
- Debug write addr 5'h03 data 8'hA5, then CPU read addr 5'h03 with RAM model -> cpu_rdata=8'hA5 on cpu_ack; dbg_rdata stays 8'h00.
- Both req held high for 8 transactions -> acks alternate CPU/debug; each ack spaced 4 cycles apart; mem_cs low in every ACK cycle.
- CPU drops cpu_req during the first ACCESS cycle -> access completes, cpu_ack still pulses once; no second grant.
- Assert n_reset low during the second ACCESS cycle of a debug write -> mem_cs=0 and dbg_ack=0 immediately; after release, state IDLE and owner=1.
- ACC_CYCLES=1, CPU read addr 5'h1F returning 8'h3C -> mem_cs high 1 cycle, cpu_ack the next cycle with cpu_rdata=8'h3C; 3-cycle period.
